// File: rtl/io_uart_tx_pkg.sv
// Shared constants and types for the uCPU memory-mapped I/O blocks.
// Register offsets, STATUS bit positions and the UART FSM states.
package ucpu_io_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/io_uart_tx_if.sv
// uCPU data-memory bus address/strobe bundle with decode feedback.
// The initiator drives abus/wr_en; a responder reports its window hit.
interface io_uart_tx_if;
  logic [7:0] abus;
  logic       wr_en;
  logic       hit;

  modport master (
    output abus,
    output wr_en,
    input  hit
  );

  modport slave (
    input  abus,
    input  wr_en,
    output hit
  );
endinterface

// File: rtl/io_uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count and full/empty flags.
// A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter responding on the uCPU data bus.
// Stores queue bytes in a FIFO; loads return status combinationally.
module io_uart_tx
  import ucpu_io_pkg::*;
#(
  parameter logic [7:0] BASE    = 8'hF0,
  parameter int         DEPTH   = 4,
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic             clk,
  input  logic             rst,
  io_uart_tx_if.slave      bus,
  inout  wire  [7:0]       dbus,
  output logic             txd,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  uart_state_e state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        ovf_q, ovf_d;
  logic        txd_q, txd_d;

  logic [1:0]  ofs;
  logic        wr_hit, rd_hit;
  logic        wr_div, wr_sts;
  logic        push, pop, full, empty;
  logic        bit_end;
  logic [7:0]  head;
  logic [7:0]  rdata;
  logic [AW:0] fcnt;

  assign bus.hit = bus.abus[7:2] == BASE[7:2];
  assign ofs     = bus.abus[1:0];
  assign wr_hit  = bus.hit && bus.wr_en;
  assign rd_hit  = bus.hit && !bus.wr_en;
  assign push    = wr_hit && (ofs == OFS_TXDATA);
  assign wr_sts  = wr_hit && (ofs == OFS_STATUS);
  assign wr_div  = wr_hit && (ofs == OFS_DIV);
  assign dbus    = rd_hit ? rdata : 8'hzz;
  assign busy    = state_q != S_IDLE;
  assign txd     = txd_q;
  assign bit_end = cnt_q == 8'd0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (dbus),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fcnt)
  );

  always_comb begin
    rdata = '0;
    unique case (ofs)
      OFS_STATUS: begin
        rdata[ST_FULL]         = full;
        rdata[ST_EMPTY]        = empty;
        rdata[ST_BUSY]         = busy;
        rdata[ST_OVF]          = ovf_q;
        rdata[ST_CNT_LO +: 4]  = 4'(fcnt);
      end
      OFS_DIV: rdata = div_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    unique case (1'b1)
      wr_div:  div_d = dbus;
      wr_sts:  if (dbus[ST_OVF]) ovf_d = 1'b0;
      default: ;
    endcase
    // a dropped byte must stay visible even if software clears ovf now
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = div_q;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          cnt_d   = div_q;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = div_q;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
        else         cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      div_q   <= DIV_RST;
      ovf_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register table plus frame-timing sequences.
// Serial frames are sampled every clock and compared bit by bit.
module tb_io_uart_tx;

  typedef struct {
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic       hit;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txd, busy;
  wire  [7:0] dbus;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_wd = 8'h00;
  int         n_vec = 0;
  int         n_bad = 0;
  int         slot_len [10];
  vec_t       tv [15];
  logic [7:0] ovf_bytes [6];

  io_uart_tx_if bif ();

  always #5 clk = ~clk;

  assign dbus = tb_oe ? tb_wd : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (dbus[i]);
  end

  io_uart_tx #(
    .BASE    (8'hF0),
    .DEPTH   (4),
    .DIV_RST (8'd3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif),
    .dbus (dbus),
    .txd  (txd),
    .busy (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    bif.abus  = 8'h00;
    bif.wr_en = 1'b0;
    tb_oe     = 1'b0;
  endtask

  task automatic apply(input bit w, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] q,
                       output logic h);
    bif.abus  = a;
    bif.wr_en = w;
    tb_wd     = d;
    tb_oe     = w;
    @(negedge clk);
    q = dbus;
    h = bif.hit;
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] q;
    logic       h;
    apply(1'b1, a, d, q, h);
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [7:0] exp);
    logic [7:0] q;
    logic       h;
    apply(1'b0, a, 8'h00, q, h);
    chk(nm, q, exp);
  endtask

  task automatic set_len(input int d);
    for (int s = 0; s < 10; s++) slot_len[s] = d + 1;
  endtask

  task automatic wait_low(input int budget, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    while (!done) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        done = 1'b1;
      end else begin
        n++;
        if (n >= budget) begin
          n    = -1;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic frame(input logic [7:0] b, input int pre, output int bad,
                       output logic [7:0] rx, output int bsy);
    logic e;
    bad = 0;
    rx  = 8'h00;
    bsy = 0;
    for (int s = 0; s < 10; s++) begin
      e = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      for (int k = 0; k < slot_len[s]; k++) begin
        if (!(s == 0 && k < pre)) begin
          @(negedge clk);
          if (txd !== e) bad++;
          if (busy === 1'b1) bsy++;
          if (k == 0 && s >= 1 && s <= 8) rx[s-1] = txd;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    logic       h;
    int         bad, bsy, gap;
    logic [7:0] rx;

    idle_bus();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset txd", txd, 1'b1);
    chk("reset busy", busy, 1'b0);

    tv[0]  = '{1'b0, 8'hF1, 8'h00, 8'h02, 1'b1};
    tv[1]  = '{1'b0, 8'hF2, 8'h00, 8'h03, 1'b1};
    tv[2]  = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b1};
    tv[3]  = '{1'b0, 8'hF3, 8'h00, 8'h00, 1'b1};
    tv[4]  = '{1'b0, 8'hEF, 8'h00, 8'hFF, 1'b0};
    tv[5]  = '{1'b0, 8'hF4, 8'h00, 8'hFF, 1'b0};
    tv[6]  = '{1'b1, 8'hF3, 8'hFF, 8'h00, 1'b1};
    tv[7]  = '{1'b0, 8'hF1, 8'h00, 8'h02, 1'b1};
    tv[8]  = '{1'b0, 8'hF2, 8'h00, 8'h03, 1'b1};
    tv[9]  = '{1'b1, 8'hF2, 8'h07, 8'h00, 1'b1};
    tv[10] = '{1'b0, 8'hF2, 8'h00, 8'h07, 1'b1};
    tv[11] = '{1'b1, 8'hF1, 8'h08, 8'h00, 1'b1};
    tv[12] = '{1'b0, 8'hF1, 8'h00, 8'h02, 1'b1};
    tv[13] = '{1'b1, 8'hF2, 8'h03, 8'h00, 1'b1};
    tv[14] = '{1'b0, 8'hF2, 8'h00, 8'h03, 1'b1};

    for (int i = 0; i < 15; i++) begin
      apply(tv[i].wr, tv[i].a, tv[i].d, q, h);
      chk($sformatf("vec%0d hit", i), h, tv[i].hit);
      if (!tv[i].wr) chk($sformatf("vec%0d data", i), q, tv[i].exp);
    end
    @(negedge clk);
    chk("table idle txd", txd, 1'b1);
    chk("table idle busy", busy, 1'b0);

    // single byte, DIV=3: busy from edge+1, txd low from edge+2
    @(posedge clk);
    #1;
    wr(8'hF0, 8'hA5);
    @(negedge clk);
    chk("a5 lat0 txd", txd, 1'b1);
    chk("a5 lat0 busy", busy, 1'b0);
    @(negedge clk);
    chk("a5 lat1 txd", txd, 1'b1);
    chk("a5 lat1 busy", busy, 1'b1);
    set_len(3);
    frame(8'hA5, 0, bad, rx, bsy);
    chk("a5 frame bits", bad, 0);
    chk("a5 frame byte", rx, 8'hA5);
    chk("a5 busy clocks", bsy + 1, 40);

    // overflow: six back-to-back stores, the sixth is dropped
    ovf_bytes[0] = 8'h11;
    ovf_bytes[1] = 8'h22;
    ovf_bytes[2] = 8'h33;
    ovf_bytes[3] = 8'h44;
    ovf_bytes[4] = 8'h55;
    ovf_bytes[5] = 8'h66;
    repeat (3) @(posedge clk);
    #1;
    wr(8'hF0, ovf_bytes[0]);
    fork
      begin : rx_side
        int         fb, fs, fg;
        logic [7:0] fr;
        @(negedge clk);
        @(negedge clk);
        frame(ovf_bytes[0], 0, fb, fr, fs);
        chk("ovf frame0 bits", fb, 0);
        chk("ovf frame0 byte", fr, ovf_bytes[0]);
        for (int j = 1; j < 5; j++) begin
          wait_low(10, fg);
          chk($sformatf("ovf gap%0d", j), fg, 1);
          frame(ovf_bytes[j], 1, fb, fr, fs);
          chk($sformatf("ovf frame%0d bits", j), fb, 0);
          chk($sformatf("ovf frame%0d byte", j), fr, ovf_bytes[j]);
        end
        wait_low(60, fg);
        chk("ovf no sixth frame", fg, -1);
      end
      begin : cpu_side
        for (int j = 1; j < 6; j++) wr(8'hF0, ovf_bytes[j]);
        rd_chk("ovf status set", 8'hF1, 8'h4D);
        wr(8'hF1, 8'h08);
        rd_chk("ovf status clr", 8'hF1, 8'h45);
      end
    join
    rd_chk("ovf status end", 8'hF1, 8'h02);

    // divisor drops to 0 while bit 2 is on the line
    wr(8'hF0, 8'h6C);
    fork
      begin : div_rx
        int         fb, fs, fg;
        logic [7:0] fr;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 10; s++) slot_len[s] = (s < 4) ? 4 : 1;
        frame(8'h6C, 0, fb, fr, fs);
        chk("div frame bits", fb, 0);
        chk("div frame byte", fr, 8'h6C);
        wait_low(20, fg);
        chk("div no extra frame", fg, -1);
      end
      begin : div_cpu
        repeat (13) @(posedge clk);
        #1;
        wr(8'hF2, 8'h00);
      end
    join
    rd_chk("div reads zero", 8'hF2, 8'h00);
    wr(8'hF2, 8'h03);
    set_len(3);

    // reset lands in bit 4 of the first of three queued frames
    wr(8'hF0, 8'h5A);
    wr(8'hF0, 8'h3C);
    wr(8'hF0, 8'hC3);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst txd", txd, 1'b1);
    chk("mid rst busy", busy, 1'b0);
    rd_chk("mid rst status", 8'hF1, 8'h02);
    wait_low(60, gap);
    chk("mid rst no frames", gap, -1);
    chk("mid rst busy after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
